// File: rtl/cte_rgb_frame_writer.sv
// Buffers engine RGB pixels in a FWFT FIFO and writes one frame to a linear frame-buffer port; overflow drops and flags.
// wr_data/wr_en follow a capture by one cycle; optional running write checksum under CTE_WR_CHKSUM_EN.
module cte_rgb_frame_writer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 16,
  parameter int FRAME_PIX = 16384
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     out_valid,
  input  logic [23:0]              rgb_out,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [23:0]              wr_data,
  input  logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     frame_done,
  output logic [23:0]              wr_chksum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_PIX + 1);
  localparam logic [PW:0]       LEVEL_FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0]     CNT_LAST   = CW'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       level_q;
  logic [PW:0]       level_d;
  logic [CW-1:0]     cap_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ovf_q;
  logic              done_q;
  logic [23:0]       mem_q [DEPTH];

  logic fifo_full;
  logic pop;
  logic capture;
  logic push;
  logic start_ok;

  assign fifo_full = (level_q == LEVEL_FULL);
  assign pop       = (level_q != '0) && wr_ready;
  assign capture   = (state_q == S_RUN) && out_valid;
  // A full FIFO still takes the pixel when the head leaves on the same edge.
  assign push      = capture && (!fifo_full || pop);
  assign start_ok  = (state_q == S_IDLE) && start;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rgb_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cap_cnt_q <= '0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      done_q  <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            cap_cnt_q <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (capture) begin
            cap_cnt_q <= cap_cnt_q + 1'b1;
            if (fifo_full && !pop) begin
              ovf_q <= 1'b1;
            end
            if (cap_cnt_q == CNT_LAST) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (level_d == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CTE_WR_CHKSUM_EN
  logic [23:0] chk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= '0;
    end else if (start_ok) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q + wr_data;
    end
  end

  assign wr_chksum = chk_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign wr_chksum       = '0;
`endif

  assign wr_en      = (level_q != '0);
  assign wr_addr    = addr_q;
  assign wr_data    = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_cte_rgb_frame_writer.sv
// Bench for cte_rgb_frame_writer: queue-based frame model compared every cycle, plus literal expectations.
module tb_cte_rgb_frame_writer;
  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 4;
  localparam int FRAME_PIX = 8;
`ifdef CTE_WR_CHKSUM_EN
  localparam logic [23:0] CHK_EXP = 24'h000003;
  localparam bit CHK_ON = 1'b1;
`else
  localparam logic [23:0] CHK_EXP = 24'h000000;
  localparam bit CHK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_valid = 1'b0;
  logic [23:0] rgb_out = '0;
  logic        wr_ready = 1'b0;
  logic        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow, busy, frame_done;
  logic [23:0] wr_chksum;

  cte_rgb_frame_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FRAME_PIX(FRAME_PIX)) dut (
    .clk(clk), .reset(reset), .start(start), .out_valid(out_valid), .rgb_out(rgb_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy), .frame_done(frame_done),
    .wr_chksum(wr_chksum)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: phase 0 idle, 1 capturing, 2 draining; FIFO held as a queue.
  int          m_phase = 0;
  logic [23:0] m_q[$];
  int          m_cnt = 0;
  int          m_addr = 0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;
  logic [23:0] m_sum = '0;

  always @(posedge clk) begin : model
    int          sz;
    int          ph;
    bit          popped;
    logic [23:0] head;
    if (reset) begin
      m_q.delete();
      m_phase = 0; m_cnt = 0; m_addr = 0; m_ovf = 1'b0; m_done = 1'b0; m_sum = '0;
    end else begin
      sz = m_q.size();
      ph = m_phase;
      m_done = 1'b0;
      popped = (sz > 0) && wr_ready;
      if (popped) begin
        head = m_q.pop_front();
        m_addr = (m_addr + 1) % FRAME_PIX;
        m_sum = m_sum + head;
      end
      if (ph == 0 && start) begin
        m_phase = 1; m_cnt = 0; m_addr = 0; m_ovf = 1'b0; m_sum = '0;
      end else if (ph == 1 && out_valid) begin
        m_cnt++;
        if (sz < DEPTH || popped) m_q.push_back(rgb_out);
        else m_ovf = 1'b1;
        if (m_cnt == FRAME_PIX) m_phase = 2;
      end else if (ph == 2 && m_q.size() == 0) begin
        m_phase = 0;
        m_done = 1'b1;
      end
    end
  end

  logic [27:0] wlog[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_en", wr_en, m_q.size() != 0);
      if (m_q.size() != 0) check("wr_data", wr_data, m_q[0]);
      check("wr_addr", wr_addr, ADDR_W'(m_addr));
      check("fifo_level", fifo_level, m_q.size());
      check("overflow", overflow, m_ovf);
      check("busy", busy, m_phase != 0);
      check("frame_done", frame_done, m_done);
      check("wr_chksum", wr_chksum, CHK_ON ? m_sum : 24'h0);
      if (wr_en && wr_ready) wlog.push_back({wr_addr, wr_data});
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pixel(input logic [23:0] d);
    out_valid = 1'b1;
    rgb_out = d;
    tick();
    out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [23:0] apix [8];
    apix[0] = 24'h000000; apix[1] = 24'hFFFFFF; apix[2] = 24'h123456; apix[3] = 24'hABCDEF;
    apix[4] = 24'h010203; apix[5] = 24'h0A0B0C; apix[6] = 24'h7F7F7F; apix[7] = 24'h800000;

    // Reset values
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_chksum", wr_chksum, 0);
    reset = 1'b0;
    tick();

    // Full frame, sink always ready
    wr_ready = 1'b1;
    do_start();
    wlog.delete();
    done_cnt = 0;
    for (int i = 0; i < 8; i++) pixel(apix[i]);
    wait_idle("A");
    tick();
    check("A_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check("A_write", wlog[i], {ADDR_W'(i), apix[i]});
    check("A_done_cnt", done_cnt, 1);
    check("A_overflow", overflow, 0);
    check("A_addr_wrap", wr_addr, 0);

    // Overflow with stalled sink
    wr_ready = 1'b0;
    do_start();
    wlog.delete();
    for (int i = 1; i <= 5; i++) pixel(24'(i));
    check("B_level", fifo_level, 4);
    check("B_overflow", overflow, 1);
    wr_ready = 1'b1;
    repeat (4) tick();
    check("B_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("B_write", wlog[i], {ADDR_W'(i), 24'(i + 1)});
    for (int i = 6; i <= 8; i++) pixel(24'(i));
    wait_idle("B");
    check("B_overflow_sticky", overflow, 1);

    // Push into full FIFO while the head pops
    wr_ready = 1'b0;
    do_start();
    check("C_ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) pixel(24'h0C0000 + 24'(i));
    check("C_full", fifo_level, 4);
    wr_ready = 1'b1;
    pixel(24'h0C0C0C);
    check("C_level_kept", fifo_level, 4);
    check("C_no_overflow", overflow, 0);
    for (int i = 0; i < 3; i++) pixel(24'h0D0000 + 24'(i));
    wait_idle("C");

    // Pixels ignored in IDLE, start ignored in RUN
    wr_ready = 1'b0;
    repeat (3) pixel(24'h00BEEF);
    check("D_idle_wr_en", wr_en, 0);
    check("D_idle_level", fifo_level, 0);
    wr_ready = 1'b1;
    do_start();
    pixel(24'h111111);
    pixel(24'h222222);
    tick();
    do_start();
    check("D_addr_kept", wr_addr, 2);
    check("D_busy", busy, 1);
    for (int i = 0; i < 6; i++) pixel(24'h333333 + 24'(i));
    wait_idle("D");

    // Reset mid-frame with buffered pixels
    wr_ready = 1'b0;
    do_start();
    pixel(24'hAAAAAA);
    pixel(24'hBBBBBB);
    check("E_level_pre", fifo_level, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("E_wr_en", wr_en, 0);
    check("E_level", fifo_level, 0);
    check("E_busy", busy, 0);
    check("E_frame_done", frame_done, 0);
    tick();
    check("E_frame_done_after", frame_done, 0);
    wr_ready = 1'b1;
    do_start();
    wlog.delete();
    pixel(24'h000055);
    tick();
    check("E_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) check("E_first_write", wlog[0], {ADDR_W'(0), 24'h000055});
    for (int i = 0; i < 7; i++) pixel(24'h440000 + 24'(i));
    wait_idle("E");

    // Checksum wraps modulo 2**24
    wr_ready = 1'b1;
    do_start();
    pixel(24'h800000);
    pixel(24'h800001);
    pixel(24'h000002);
    tick();
    check("F_chksum", wr_chksum, CHK_EXP);
    for (int i = 0; i < 5; i++) pixel(24'h550000 + 24'(i));
    wait_idle("F");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom % 20) == 0;
      reset     = ($urandom % 300) == 0;
      out_valid = ($urandom % 3) != 0;
      wr_ready  = ($urandom % 2) != 0;
      rgb_out   = 24'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; out_valid = 1'b0; wr_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
